// File: rtl/control_pkg.sv
// Shared types and constants for the control FSM opcode path: sequencer states,
// forced BRK opcode, default vectors and the per-state inhibit/flag outputs.
package control_pkg;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_FETCH   = 2'd2,
        S_SERVICE = 2'd3
    } state_t;

    localparam logic [7:0]  BRK_OPCODE     = 8'h00;
    localparam logic [15:0] DEF_NMI_VEC    = 16'hFFFA;
    localparam logic [15:0] DEF_RESET_VEC  = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC    = 16'hFFFE;

    typedef struct packed {
        logic int_active;
        logic pc_inc_inhibit;
        logic write_inhibit;
        logic b_flag;
    } ctrl_flags_t;

    // Flag outputs are a pure function of the state they accompany.
    function automatic ctrl_flags_t flags_for(input state_t s);
        ctrl_flags_t f;
        f = '0;
        case (s)
            S_RESET: begin
                f.int_active     = 1'b1;
                f.pc_inc_inhibit = 1'b1;
                f.write_inhibit  = 1'b1;
                f.b_flag         = 1'b0;
            end
            S_RUN: begin
                f.b_flag         = 1'b1;
            end
            S_FETCH, S_SERVICE: begin
                f.int_active     = 1'b1;
                f.pc_inc_inhibit = 1'b1;
                f.b_flag         = 1'b0;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pin_sync.sv
// N-stage synchroniser for an asynchronous active-low pin; reset presets every
// stage to 1 so the pin reads idle until real samples arrive.
module pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt front end: synchronises NMI/IRQ pins, arbitrates them at instruction
// boundaries and forces a BRK opcode plus vector/inhibits until the vector fetch.
module interrupt_sequencer
    import control_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC     = DEF_NMI_VEC,
    parameter logic [15:0] RESET_VEC   = DEF_RESET_VEC,
    parameter logic [15:0] IRQ_VEC     = DEF_IRQ_VEC
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        nmib_in,
    input  logic        irqb_in,
    input  logic        p_i,
    input  logic        last_cycle,
    input  logic        vector_ack,
    input  logic [7:0]  data_in,
    output logic [7:0]  opcode_out,
    output logic [15:0] vector_addr,
    output logic        b_flag,
    output logic        pc_inc_inhibit,
    output logic        write_inhibit,
    output logic        int_active,
    output state_t      dbg_state
);

    // Handshake: vector_ack is a single-cycle strobe from the control FSM saying
    // the high byte of vector_addr was fetched this cycle; it is sampled on the
    // rising edge of ph1 and closes the in-service event (no ready back-pressure).

    logic        nmib_s;
    logic        irqb_s;
    logic        nmib_prev_q;
    logic        nmi_pending_q, nmi_pending_d;
    logic        svc_nmi_q, svc_nmi_d;
    state_t      state_q, state_d;
    ctrl_flags_t flags_q;
    logic        irq_req;
    logic        nmi_edge;
    logic        use_nmi;
    logic        nmi_serviced;

    pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk_i  (ph1),
        .rst_i  (reset),
        .pin_i  (nmib_in),
        .sync_o (nmib_s)
    );

    pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk_i  (ph1),
        .rst_i  (reset),
        .pin_i  (irqb_in),
        .sync_o (irqb_s)
    );

    assign irq_req  = ~irqb_s & ~p_i;
    assign nmi_edge = nmib_prev_q & ~nmib_s;

    // A pending NMI hijacks whichever vector fetch is outstanding, except the reset sequence.
    always_comb begin
        use_nmi = 1'b0;
        case (state_q)
            S_RESET:            use_nmi = 1'b0;
            S_RUN:              use_nmi = nmi_pending_q;
            S_FETCH, S_SERVICE: use_nmi = svc_nmi_q | nmi_pending_q;
            default:            use_nmi = 1'b0;
        endcase
    end

    assign nmi_serviced  = vector_ack & use_nmi;
    assign nmi_pending_d = (nmi_pending_q & ~nmi_serviced) | nmi_edge;

    always_comb begin
        state_d   = state_q;
        svc_nmi_d = svc_nmi_q;
        case (state_q)
            S_RESET: begin
                if (vector_ack) state_d = S_RUN;
            end
            S_RUN: begin
                if (last_cycle && (nmi_pending_q || irq_req)) begin
                    state_d   = S_FETCH;
                    svc_nmi_d = nmi_pending_q;
                end
            end
            S_FETCH: begin
                state_d = S_SERVICE;
            end
            S_SERVICE: begin
                if (vector_ack) begin
                    state_d   = S_RUN;
                    svc_nmi_d = 1'b0;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q       <= S_RESET;
            flags_q       <= flags_for(S_RESET);
            svc_nmi_q     <= 1'b0;
            nmi_pending_q <= 1'b0;
            nmib_prev_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_for(state_d);
            svc_nmi_q     <= svc_nmi_d;
            nmi_pending_q <= nmi_pending_d;
            nmib_prev_q   <= nmib_s;
        end
    end

    always_comb begin
        opcode_out = data_in;
        if (state_q == S_RESET || state_q == S_FETCH) opcode_out = BRK_OPCODE;
    end

    always_comb begin
        if (state_q == S_RESET) vector_addr = RESET_VEC;
        else if (use_nmi)       vector_addr = NMI_VEC;
        else                    vector_addr = IRQ_VEC;
    end

    assign b_flag         = flags_q.b_flag;
    assign pc_inc_inhibit = flags_q.pc_inc_inhibit;
    assign write_inhibit  = flags_q.write_inhibit;
    assign int_active     = flags_q.int_active;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: scripted pin/boundary scenarios
// with expected output words queued by the driver and compared at the falling edge.
module tb_interrupt_sequencer;
    import control_pkg::*;

    localparam logic [15:0] V_NMI = 16'hFFFA;
    localparam logic [15:0] V_RST = 16'hFFFC;
    localparam logic [15:0] V_IRQ = 16'hFFFE;

    logic        ph1;
    logic        reset;
    logic        nmib_in;
    logic        irqb_in;
    logic        p_i;
    logic        last_cycle;
    logic        vector_ack;
    logic [7:0]  data_in;
    logic [7:0]  opcode_out;
    logic [15:0] vector_addr;
    logic        b_flag;
    logic        pc_inc_inhibit;
    logic        write_inhibit;
    logic        int_active;
    state_t      dbg_state;

    logic [27:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [27:0] exp_w;
    string       exp_tag;

    interrupt_sequencer dut (
        .ph1            (ph1),
        .reset          (reset),
        .nmib_in        (nmib_in),
        .irqb_in        (irqb_in),
        .p_i            (p_i),
        .last_cycle     (last_cycle),
        .vector_ack     (vector_ack),
        .data_in        (data_in),
        .opcode_out     (opcode_out),
        .vector_addr    (vector_addr),
        .b_flag         (b_flag),
        .pc_inc_inhibit (pc_inc_inhibit),
        .write_inhibit  (write_inhibit),
        .int_active     (int_active),
        .dbg_state      (dbg_state)
    );

    // clock
    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    function automatic logic [27:0] obs_word();
        return {opcode_out, vector_addr, b_flag, pc_inc_inhibit, write_inhibit, int_active};
    endfunction

    // word layout: {opcode, vector, b_flag, pc_inc_inhibit, write_inhibit, int_active}
    function automatic logic [27:0] w_run(input logic [7:0] d, input logic [15:0] v);
        return {d, v, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic logic [27:0] w_fetch(input logic [15:0] v);
        return {8'h00, v, 1'b0, 1'b1, 1'b0, 1'b1};
    endfunction

    function automatic logic [27:0] w_serv(input logic [7:0] d, input logic [15:0] v);
        return {d, v, 1'b0, 1'b1, 1'b0, 1'b1};
    endfunction

    function automatic logic [27:0] w_rst();
        return {8'h00, V_RST, 1'b0, 1'b1, 1'b1, 1'b1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // scoreboard: pop one expectation per falling edge when one is queued
    always @(negedge ph1) begin
        if (exp_q.size() != 0) begin
            exp_w   = exp_q.pop_front();
            exp_tag = tag_q.pop_front();
            check_eq(exp_tag, {4'h0, obs_word()}, {4'h0, exp_w});
        end
    end

    task automatic drive(input logic lc, input logic ack, input logic [7:0] din,
                         input logic [27:0] e, input string tag);
        last_cycle = lc;
        vector_ack = ack;
        data_in    = din;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge ph1);
        #1;
    endtask

    task automatic idle(input int n, input logic [15:0] v, input string tag);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(1, 255));
            drive(1'b0, 1'b0, d, w_run(d, v), tag);
        end
    endtask

    initial begin
        reset      = 1'b0;
        nmib_in    = 1'b1;
        irqb_in    = 1'b1;
        p_i        = 1'b1;
        last_cycle = 1'b0;
        vector_ack = 1'b0;
        data_in    = 8'hA9;
        #1 reset = 1'b1;
        repeat (3) @(posedge ph1);
        #1;
        check_eq("reset_state", {4'h0, obs_word()}, {4'h0, w_rst()});
        reset = 1'b0;

        // reset sequence then pass-through
        drive(1'b0, 1'b0, 8'hA9, w_rst(), "rst_hold");
        drive(1'b0, 1'b1, 8'hA9, w_rst(), "rst_ack_cycle");
        drive(1'b0, 1'b0, 8'hA9, w_run(8'hA9, V_IRQ), "run_a9");
        drive(1'b0, 1'b0, 8'h3C, w_run(8'h3C, V_IRQ), "run_3c");

        // unmasked IRQ
        irqb_in = 1'b0; p_i = 1'b0;
        idle(3, V_IRQ, "irq_sync");
        drive(1'b1, 1'b0, 8'hEA, w_run(8'hEA, V_IRQ), "irq_boundary");
        drive(1'b0, 1'b0, 8'hEA, w_fetch(V_IRQ), "irq_fetch");
        irqb_in = 1'b1;
        drive(1'b0, 1'b1, 8'h55, w_serv(8'h55, V_IRQ), "irq_service");
        drive(1'b0, 1'b0, 8'h55, w_run(8'h55, V_IRQ), "irq_done");
        idle(3, V_IRQ, "irq_idle");

        // masked IRQ, then unmask
        irqb_in = 1'b0; p_i = 1'b1;
        idle(3, V_IRQ, "mask_sync");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h11, w_run(8'h11, V_IRQ), "mask_boundary");
            drive(1'b0, 1'b0, 8'h22, w_run(8'h22, V_IRQ), "mask_no_inject");
        end
        p_i = 1'b0;
        drive(1'b1, 1'b0, 8'h33, w_run(8'h33, V_IRQ), "unmask_boundary");
        drive(1'b0, 1'b0, 8'h33, w_fetch(V_IRQ), "unmask_fetch");
        drive(1'b0, 1'b1, 8'h44, w_serv(8'h44, V_IRQ), "unmask_service");
        irqb_in = 1'b1; p_i = 1'b1;
        drive(1'b0, 1'b0, 8'h44, w_run(8'h44, V_IRQ), "unmask_done");
        idle(3, V_IRQ, "unmask_idle");

        // NMI held low: one service only
        nmib_in = 1'b0;
        idle(3, V_IRQ, "nmi_sync");
        drive(1'b1, 1'b0, 8'h66, w_run(8'h66, V_NMI), "nmi_boundary");
        drive(1'b0, 1'b0, 8'h66, w_fetch(V_NMI), "nmi_fetch");
        drive(1'b0, 1'b1, 8'h77, w_serv(8'h77, V_NMI), "nmi_service");
        drive(1'b0, 1'b0, 8'h77, w_run(8'h77, V_IRQ), "nmi_cleared");
        drive(1'b1, 1'b0, 8'h88, w_run(8'h88, V_IRQ), "nmi_held_boundary");
        drive(1'b0, 1'b0, 8'h88, w_run(8'h88, V_IRQ), "nmi_no_retrigger");
        nmib_in = 1'b1;
        idle(3, V_IRQ, "nmi_release");
        nmib_in = 1'b0;
        idle(3, V_IRQ, "nmi_refall_sync");
        drive(1'b0, 1'b0, 8'h99, w_run(8'h99, V_NMI), "nmi2_pending");
        drive(1'b1, 1'b0, 8'h99, w_run(8'h99, V_NMI), "nmi2_boundary");
        drive(1'b0, 1'b0, 8'h99, w_fetch(V_NMI), "nmi2_fetch");
        drive(1'b0, 1'b1, 8'hAA, w_serv(8'hAA, V_NMI), "nmi2_service");
        drive(1'b0, 1'b0, 8'hAA, w_run(8'hAA, V_IRQ), "nmi2_done");
        nmib_in = 1'b1;
        idle(3, V_IRQ, "nmi2_release");

        // NMI hijacks an IRQ service
        irqb_in = 1'b0; p_i = 1'b0;
        idle(3, V_IRQ, "hij_sync");
        drive(1'b1, 1'b0, 8'hBB, w_run(8'hBB, V_IRQ), "hij_boundary");
        drive(1'b0, 1'b0, 8'hBB, w_fetch(V_IRQ), "hij_fetch");
        nmib_in = 1'b0; irqb_in = 1'b1; p_i = 1'b1;
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 8'hCC, w_serv(8'hCC, V_IRQ), "hij_serv_irq");
        drive(1'b0, 1'b1, 8'hCC, w_serv(8'hCC, V_NMI), "hij_serv_nmi");
        drive(1'b0, 1'b0, 8'hDD, w_run(8'hDD, V_IRQ), "hij_done");
        drive(1'b1, 1'b0, 8'hDD, w_run(8'hDD, V_IRQ), "hij_boundary2");
        drive(1'b0, 1'b0, 8'hDD, w_run(8'hDD, V_IRQ), "hij_no_extra");
        nmib_in = 1'b1;
        idle(3, V_IRQ, "hij_release");

        // simultaneous NMI and IRQ, then reset mid-service
        irqb_in = 1'b0; p_i = 1'b0; nmib_in = 1'b0;
        idle(3, V_IRQ, "both_sync");
        drive(1'b1, 1'b0, 8'hE1, w_run(8'hE1, V_NMI), "both_boundary");
        drive(1'b0, 1'b0, 8'hE1, w_fetch(V_NMI), "both_fetch_nmi");
        drive(1'b0, 1'b1, 8'hE2, w_serv(8'hE2, V_NMI), "both_serv_nmi");
        drive(1'b1, 1'b0, 8'hE3, w_run(8'hE3, V_IRQ), "both_boundary2");
        drive(1'b0, 1'b0, 8'hE3, w_fetch(V_IRQ), "both_fetch_irq");
        nmib_in = 1'b1; irqb_in = 1'b1; p_i = 1'b1; data_in = 8'hE4;
        #1;
        check_eq("pre_reset_service", {4'h0, obs_word()}, {4'h0, w_serv(8'hE4, V_IRQ)});
        reset = 1'b1;
        #1;
        check_eq("reset_mid_service", {4'h0, obs_word()}, {4'h0, w_rst()});
        @(posedge ph1);
        @(posedge ph1);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'hF0, w_rst(), "post_rst_hold");
        drive(1'b0, 1'b1, 8'hF0, w_rst(), "post_rst_ack");
        idle(3, V_IRQ, "post_rst_run");

        check_eq("queue_drain", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
